// File: rtl/seq_arith_unit_pkg.sv
// seq_calc_pkg: shared types, width constants and helpers for the
// sequential arithmetic unit.
//   W        operand/accumulator width (two's complement)
//   CNT_W    width of the multiplier bit counter
//   ACC_MAX  largest representable value,  2^(W-1)-1
//   ACC_MIN  smallest representable value, -2^(W-1)
//   op_t     LOAD / ADD / SUB / MUL request encoding
//   state_t  control FSM states
//   abs_w()  W-bit magnitude; -2^(W-1) maps to unsigned 2^(W-1)
package seq_calc_pkg;

  localparam int W     = 11;
  localparam int CNT_W = $clog2(W);

  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  // Negating the most negative value wraps back onto itself, which read as
  // unsigned is exactly its magnitude, so no special case is needed.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    if (x[W-1]) begin
      abs_w = ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      abs_w = x;
    end
  endfunction

endpackage

// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if: request/result bundle of the arithmetic unit.
//   start    request strobe, sampled only while the unit is idle
//   op       operation (op_t)
//   operand  signed W-bit operand B
//   acc      signed W-bit accumulator (drives the display TC input)
//   busy     high while a multiply iterates
//   done     one-cycle pulse when acc/ovf update
//   ovf      last operation overflowed
// Modports: master = requester, slave = arithmetic unit.
interface seq_arith_unit_if;
  import seq_calc_pkg::*;

  logic         start;
  op_t          op;
  logic [W-1:0] operand;
  logic [W-1:0] acc;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start, op, operand,
    input  acc, busy, done, ovf
  );

  modport slave (
    input  start, op, operand,
    output acc, busy, done, ovf
  );

endinterface

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: unsigned W x W shift-add multiplier, one multiplicand
// bit per cycle, W cycles per product.
//   clk, reset  clock / asynchronous active-high reset
//   go          load operands, clear product, start iterating
//   mcand_in    multiplicand (examined LSB first)
//   mplier_in   multiplier (shifted into place and added)
//   cnt         remaining-step counter, W-1 down to 0
//   prod        2W-bit product, final after the cnt==0 step
module seq_shift_add_mult
  import seq_calc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [W-1:0]     mcand_in,
  input  logic [W-1:0]     mplier_in,
  output logic [CNT_W-1:0] cnt,
  output logic [2*W-1:0]   prod
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(W - 1);

  logic [W-1:0]     mcand_r;
  logic [W-1:0]     mplier_r;
  logic             active_r;
  logic [CNT_W-1:0] shamt;
  logic [2*W-1:0]   addend;

  // Partial product for this step: multiplier weighted by the bit position
  // of the multiplicand bit currently in mcand_r[0].
  always_comb begin
    shamt = CNT_TOP - cnt;
    if (mcand_r[0]) begin
      addend = {{W{1'b0}}, mplier_r} << shamt;
    end else begin
      addend = {(2*W){1'b0}};
    end
  end

  // Iteration state: load on go, then accumulate and shift until cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= {W{1'b0}};
      mplier_r <= {W{1'b0}};
      active_r <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      prod     <= {(2*W){1'b0}};
    end else if (go) begin
      mcand_r  <= mcand_in;
      mplier_r <= mplier_in;
      active_r <= 1'b1;
      cnt      <= CNT_TOP;
      prod     <= {(2*W){1'b0}};
    end else if (active_r) begin
      prod    <= prod + addend;
      mcand_r <= mcand_r >> 1;
      if (cnt == {CNT_W{1'b0}}) begin
        active_r <= 1'b0;
      end else begin
        cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: accumulator-based LOAD/ADD/SUB/MUL core feeding the
// binary-to-7-segment display.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state (aborts a MUL)
//   bus    seq_arith_unit_if.slave: start/op/operand in, acc/busy/done/ovf out
// LOAD/ADD/SUB complete at the accepting edge; MUL runs W cycles in the
// shift-add core plus one FIN cycle for sign and range handling.
// Build option: define SEQ_ARITH_SATURATE_EN to clamp acc on overflow
// instead of wrapping to the low W bits.
module seq_arith_unit
  import seq_calc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  seq_arith_unit_if.slave bus
);

  localparam logic [2*W-1:0] MAG_POS_LIM = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] MAG_NEG_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [2*W-1:0] PROD_ZERO   = {(2*W){1'b0}};
  localparam logic [2*W-1:0] PROD_ONE    = {{(2*W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     acc_nxt;
  logic             ovf_r;
  logic             ovf_nxt;
  logic             busy_r;
  logic             busy_nxt;
  logic             done_r;
  logic             done_nxt;
  logic             neg_r;

  logic             mul_go;
  logic             mul_last;
  logic [CNT_W-1:0] mul_cnt;
  logic [2*W-1:0]   mul_prod;

  logic [W:0]       sum;
  logic             add_ovf;
  logic [W-1:0]     add_res;
  logic             res_neg;
  logic [2*W-1:0]   prod_neg;
  logic             mul_ovf;
  logic [W-1:0]     mul_res;

  assign mul_go   = (state_r == ST_IDLE) && bus.start && (bus.op == OP_MUL);
  assign mul_last = (state_r == ST_MUL) && (mul_cnt == {CNT_W{1'b0}});

  seq_shift_add_mult u_mult (
    .clk       (clk),
    .reset     (reset),
    .go        (mul_go),
    .mcand_in  (abs_w(bus.operand)),
    .mplier_in (abs_w(acc_r)),
    .cnt       (mul_cnt),
    .prod      (mul_prod)
  );

  // ADD/SUB in W+1 bits; the two top bits disagree exactly on overflow.
  always_comb begin
    if (bus.op == OP_SUB) begin
      sum = {acc_r[W-1], acc_r} - {bus.operand[W-1], bus.operand};
    end else begin
      sum = {acc_r[W-1], acc_r} + {bus.operand[W-1], bus.operand};
    end
    add_ovf = sum[W] ^ sum[W-1];
`ifdef SEQ_ARITH_SATURATE_EN
    if (add_ovf) begin
      add_res = sum[W] ? ACC_MIN : ACC_MAX;
    end else begin
      add_res = sum[W-1:0];
    end
`else
    add_res = sum[W-1:0];
`endif
  end

  // MUL result: re-apply the sign to the magnitude; a zero product is
  // always positive, and the negative range reaches one step further.
  always_comb begin
    res_neg  = neg_r && (mul_prod != PROD_ZERO);
    prod_neg = ~mul_prod + PROD_ONE;
    if (res_neg) begin
      mul_ovf = (mul_prod > MAG_NEG_LIM);
    end else begin
      mul_ovf = (mul_prod > MAG_POS_LIM);
    end
`ifdef SEQ_ARITH_SATURATE_EN
    if (mul_ovf) begin
      mul_res = res_neg ? ACC_MIN : ACC_MAX;
    end else if (res_neg) begin
      mul_res = prod_neg[W-1:0];
    end else begin
      mul_res = mul_prod[W-1:0];
    end
`else
    if (res_neg) begin
      mul_res = prod_neg[W-1:0];
    end else begin
      mul_res = mul_prod[W-1:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && (bus.op == OP_MUL)) begin
          state_nxt = ST_MUL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_MUL;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered acc/ovf/busy/done.
  always_comb begin
    acc_nxt  = acc_r;
    ovf_nxt  = ovf_r;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_LOAD: begin
              acc_nxt  = bus.operand;
              ovf_nxt  = 1'b0;
              done_nxt = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              acc_nxt  = add_res;
              ovf_nxt  = add_ovf;
              done_nxt = 1'b1;
            end
            OP_MUL:  busy_nxt = 1'b1;
            default: busy_nxt = 1'b0;
          endcase
        end else begin
          busy_nxt = 1'b0;
        end
      end
      // busy drops on the edge that leaves MUL, so it covers exactly W cycles.
      ST_MUL: busy_nxt = !mul_last;
      ST_FIN: begin
        acc_nxt  = mul_res;
        ovf_nxt  = mul_ovf;
        done_nxt = 1'b1;
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r  <= {W{1'b0}};
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      acc_r  <= acc_nxt;
      ovf_r  <= ovf_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
    end
  end

  // Result sign of the multiply in flight, captured when it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_r <= 1'b0;
    end else if (mul_go) begin
      neg_r <= acc_r[W-1] ^ bus.operand[W-1];
    end else begin
      neg_r <= neg_r;
    end
  end

  assign bus.acc  = acc_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
